// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: per-master request bundle plus the single shared external memory bus.
// The slave modport is the arbiter's view; the master modport is the view of the masters and the memory.
interface mem_bus_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    m_req;
    logic [32*NUM_REQ-1:0] m_addr;
    logic [2*NUM_REQ-1:0]  m_burst;
    logic [NUM_REQ-1:0]    m_wrb;
    logic [32*NUM_REQ-1:0] m_wdata;
    logic [4*NUM_REQ-1:0]  m_bstrobe;
    logic [NUM_REQ-1:0]    m_ack;
    logic [NUM_REQ-1:0]    m_stall;
    logic [31:0]           m_rdata;
    logic [NUM_REQ-1:0]    m_err;
    logic [31:0]           ADDR;
    logic [1:0]            BURST;
    logic                  REQ;
    logic                  WRB;
    logic [31:0]           WDATA;
    logic [3:0]            BSTROBE;
    logic [31:0]           RDATA;
    logic                  ACK;
    logic                  STALL;

    modport slave (
        input  m_req, m_addr, m_burst, m_wrb, m_wdata, m_bstrobe,
        output m_ack, m_stall, m_rdata, m_err,
        output ADDR, BURST, REQ, WRB, WDATA, BSTROBE,
        input  RDATA, ACK, STALL
    );

    modport master (
        output m_req, m_addr, m_burst, m_wrb, m_wdata, m_bstrobe,
        input  m_ack, m_stall, m_rdata, m_err,
        input  ADDR, BURST, REQ, WRB, WDATA, BSTROBE,
        output RDATA, ACK, STALL
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one external memory bus among NUM_REQ masters.
// Define MEM_ARB_TIMEOUT_EN to build a watchdog that aborts a transaction after TIMEOUT_CYCLES without ACK.
module mem_bus_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int BURST_LEN      = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               proc_clk,
    input  logic               proc_rst,
    mem_bus_arbiter_if.slave   bus,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(BURST_LEN + 1);

    if (NUM_REQ < 1 || BURST_LEN < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("mem_bus_arbiter: NUM_REQ, BURST_LEN and TIMEOUT_CYCLES must all be at least 1");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]      last_q, last_d, win;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         win_burst;
    logic               found, req_g, ack_g, timeout;

    assign busy        = state_q == BUSY;
    assign gnt         = gnt_q;
    assign req_g       = |(bus.m_req & gnt_q);
    assign ack_g       = busy & bus.ACK;
    assign bus.m_rdata = bus.RDATA;

    // Round-robin pick: first requester above the last winner, else the lowest requester (wrap-around).
    always_comb begin
        win       = last_q;
        win_burst = 2'b00;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            if (!found && bus.m_req[i] && IW'(i) > last_q) begin
                win   = IW'(i);
                found = 1'b1;
            end
        for (int i = 0; i < NUM_REQ; i++)
            if (!found && bus.m_req[i]) begin
                win   = IW'(i);
                found = 1'b1;
            end
        for (int i = 0; i < NUM_REQ; i++)
            if (win == IW'(i)) win_burst = bus.m_burst[2*i +: 2];
    end

    // Next state: grant from IDLE; in BUSY count beats and release on completion, abort or timeout.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (|bus.m_req) begin
                state_d = BUSY;
                gnt_d   = NUM_REQ'(1) << win;
                last_d  = win;
                cnt_d   = (win_burst == 2'b01 || win_burst == 2'b10) ? CW'(BURST_LEN) : CW'(1);
            end
        end else begin
            cnt_d = ack_g ? cnt_q - CW'(1) : cnt_q;
            if (!req_g || timeout || (ack_g && cnt_q == CW'(1))) begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        end
    end

    // State, grant, round-robin pointer and beat counter; the pointer resets to the top so master 0 wins first.
    always_ff @(posedge proc_clk or posedge proc_rst) begin
        if (proc_rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory side follows the granted master; everyone else sees stall and no ACK.
    always_comb begin
        bus.ADDR    = '0;
        bus.BURST   = '0;
        bus.REQ     = 1'b0;
        bus.WRB     = 1'b0;
        bus.WDATA   = '0;
        bus.BSTROBE = '0;
        bus.m_ack   = '0;
        bus.m_stall = '1;
        bus.m_err   = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt_q[i]) begin
                bus.ADDR       = bus.m_addr[32*i +: 32];
                bus.BURST      = bus.m_burst[2*i +: 2];
                bus.REQ        = bus.m_req[i] & ~timeout;
                bus.WRB        = bus.m_wrb[i];
                bus.WDATA      = bus.m_wdata[32*i +: 32];
                bus.BSTROBE    = bus.m_bstrobe[4*i +: 4];
                bus.m_ack[i]   = bus.ACK;
                bus.m_stall[i] = bus.STALL;
                bus.m_err[i]   = timeout;
            end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] wdog_q, wdog_d;

    assign timeout = busy && wdog_q == WW'(TIMEOUT_CYCLES);

    // Watchdog: held at zero in IDLE and on every ACK, counts each BUSY cycle without ACK.
    always_comb wdog_d = (!busy || bus.ACK) ? '0 : wdog_q + WW'(1);

    // Watchdog register.
    always_ff @(posedge proc_clk or posedge proc_rst) begin
        if (proc_rst) wdog_q <= '0;
        else          wdog_q <= wdog_d;
    end
`else
    assign timeout = 1'b0;
`endif
endmodule
